btn_mem_cmd_seq: RTL and testbench
==================================

Name: btn_mem_cmd_seq

Overview:
Clocked, parametrised successor to the combinational button-to-memory write decoder. It synchronises and debounces N_BTN active-low push-buttons and detects press events. Each press becomes exactly one memory command (write of a button-specific value, or a read) held under a req/ack handshake toward the memory-port arbiter. Sits between board button pins and the data-memory write port.

Parameters:
N_BTN, 3, number of active-low buttons (2..8); button N_BTN-1 is the read button, all others are write buttons
ADDR_W, 32, address width
DATA_W, 32, data width
DEB_CYC, 4, cycles a synchronised level must stay stable before it is accepted (>=1)
BASE_ADDR, 1, command address
IDLE_ADDR, 15, address driven while no command is pending

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous
wr_en  out  1  write request, held until ack
rd_en  out  1  read request, held until ack
addr  out  ADDR_W  command address
data  out  DATA_W  write data; valid only while wr_en=1
cmd_ack  in  1  memory accepted current command this cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high; takes priority over all other logic, including mid-command): wr_en=0, rd_en=0, addr=IDLE_ADDR, data=0, busy=0, FSM=IDLE. Synchroniser flops load 1 (released). Debounced levels are set to released. Debounce counters are set to 0.
- Input path: per-bit 2-flop synchroniser, then debounce. The counter resets on any change. The level is accepted after DEB_CYC consecutive equal samples. A press event is a debounced 1->0 transition. Latency from raw press to press event: 2+DEB_CYC cycles.
- Priority: when several press events occur in the same cycle, the lowest index wins and the others are discarded.
- FSM states: IDLE, REQ, RELEASE.
- IDLE -> REQ on a press event of button i:
  - i<N_BTN-1: next cycle wr_en=1, addr=BASE_ADDR, data=i+1 (zero-extended to DATA_W).
  - i=N_BTN-1: next cycle rd_en=1, addr=BASE_ADDR, data=0.
- REQ: hold wr_en/rd_en, addr and data stable until cmd_ack=1.
  - The cycle ack is sampled high, the command completes.
  - The next cycle wr_en=rd_en=0, addr=IDLE_ADDR; go to RELEASE.
- cmd_ack is ignored in IDLE and RELEASE.
- RELEASE: wait until all debounced buttons are released, then go to IDLE. Press events are ignored here, so one press produces exactly one command.
- A button still held when the FSM returns to IDLE does not retrigger; only a new 1->0 debounced edge does.
- Glitches shorter than DEB_CYC cycles produce no event.
- wr_en and rd_en are never high together.

Optional Feature:
BTN_MEM_AUTO_INC_EN
- Defined: an internal write pointer (reset to BASE_ADDR) supplies addr for write commands. The pointer increments by 1 on each acknowledged write. After BASE_ADDR+15 it wraps to BASE_ADDR (16-entry window). Read commands use the last written address: pointer-1, wrapping to BASE_ADDR+15 when the pointer is BASE_ADDR. A read before any write reads BASE_ADDR.
- Undefined: all commands use BASE_ADDR; no pointer logic is present.

Decomposition:
- Package btn_mem_pkg:
  - state enum (IDLE, REQ, RELEASE);
  - auto-increment window constant AUTO_WIN=16.
- Sub-module btn_debounce: one bit, containing the synchroniser, DEB_CYC counter, debounced level and press pulse. Instantiated N_BTN times in a generate loop.

Test Plan:
- Reset for 3 cycles while btn=3'b110 is held -> outputs at reset values and no command; after release and a new press, exactly one write.
- btn 3'b111->3'b110, held 10 cycles, ack 2 cycles after wr_en rises -> wr_en=1 with addr=1 and data=1, stable until ack; then addr=15; exactly one write.
- Press btn[1] (3'b101) and btn[0] in the same cycle -> single write with data=1; no second command while either is held.
- btn 3'b011 with ack held constantly high -> rd_en=1 for exactly 1 cycle, addr=1, wr_en=0.
- 2-cycle low glitch on btn[0] with DEB_CYC=4 -> no command; busy stays 0.
- With BTN_MEM_AUTO_INC_EN: 17 acked writes -> addrs 1..16 then 1; following read -> addr=1.

Source files
------------

// File: rtl/btn_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_mem_pkg
//  Description : Shared types and constants for the button-driven memory
//                command sequencer (FSM state encoding, auto-increment
//                window size).
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_mem_pkg;

  // Command sequencer states: wait for a press, hold a request, wait for release
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Number of addresses covered by the auto-incrementing write pointer
  localparam int unsigned AUTO_WIN = 16;

endpackage : btn_mem_pkg
`default_nettype wire

// File: rtl/btn_mem_cmd_seq_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One active-low button: 2-flop synchroniser, stability
//                counter, debounced level and a one-cycle press pulse on a
//                debounced 1->0 transition. Raw press to press pulse takes
//                2 + DEB_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import btn_mem_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise the raw pin, then accept a new level only once the
  // synchronised value has differed from the accepted level for DEB_CYC
  // consecutive samples; any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/btn_mem_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : btn_mem_cmd_seq
//  Description : Debounces N_BTN active-low buttons and turns each press into
//                exactly one memory command (write of index+1, or a read for
//                the top button) held under a req/ack handshake.
//                Optional feature macro: BTN_MEM_AUTO_INC_EN (auto-incrementing
//                write pointer over a 16-entry window).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_mem_cmd_seq
  import btn_mem_pkg::*;
#(
  parameter int          N_BTN     = 3,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          DEB_CYC   = 4,
  parameter int unsigned BASE_ADDR = 1,
  parameter int unsigned IDLE_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              cmd_ack,
  output logic              busy
);

  localparam int IDX_W = (N_BTN < 2) ? 1 : $clog2(N_BTN);
  localparam logic [ADDR_W-1:0] C_BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_IDLE   = ADDR_W'(IDLE_ADDR);
  localparam logic [IDX_W-1:0]  C_RD_IDX = IDX_W'(N_BTN - 1);

  logic [N_BTN-1:0]  w_level;
  logic [N_BTN-1:0]  w_press;
  logic              w_any_press;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_all_released;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  state_e            state_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;

  generate
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_debounce #(
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn[g]),
        .level_o   (w_level[g]),
        .press_o   (w_press[g])
      );
    end
  endgenerate

  // Lowest-index press wins; scanning downward lets the lowest hit land last
  always_comb begin
    w_any_press = |w_press;
    w_sel_idx   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_press[i]) begin
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  assign w_all_released = &w_level;

`ifdef BTN_MEM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] C_LAST = C_BASE + ADDR_W'(AUTO_WIN - 1);

  logic [ADDR_W-1:0] ptr_q;
  logic              wrote_q;

  // Advance the write pointer on every acknowledged write, wrapping in the window
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= C_BASE;
      wrote_q <= 1'b0;
    end else if ((state_q == ST_REQ) && wr_en_q && cmd_ack) begin
      ptr_q   <= (ptr_q == C_LAST) ? C_BASE : ptr_q + ADDR_W'(1);
      wrote_q <= 1'b1;
    end
  end

  // Reads target the most recently written address; before any write, the base
  assign w_wr_addr = ptr_q;
  assign w_rd_addr = !wrote_q          ? C_BASE :
                     (ptr_q == C_BASE) ? C_LAST :
                                         ptr_q - ADDR_W'(1);
`else
  assign w_wr_addr = C_BASE;
  assign w_rd_addr = C_BASE;
`endif

  // Command FSM with registered handshake, address, data and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= C_IDLE;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any_press) begin
            state_q <= ST_REQ;
            busy_q  <= 1'b1;
            if (w_sel_idx == C_RD_IDX) begin
              rd_en_q <= 1'b1;
              addr_q  <= w_rd_addr;
              data_q  <= '0;
            end else begin
              wr_en_q <= 1'b1;
              addr_q  <= w_wr_addr;
              data_q  <= DATA_W'(w_sel_idx) + DATA_W'(1);
            end
          end
        end
        ST_REQ: begin
          if (cmd_ack) begin
            state_q <= ST_RELEASE;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= C_IDLE;
            data_q  <= '0;
          end
        end
        ST_RELEASE: begin
          // Presses here are swallowed so one physical press yields one command
          if (w_all_released) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          addr_q  <= C_IDLE;
          data_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en = wr_en_q;
  assign rd_en = rd_en_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign busy  = busy_q;

endmodule : btn_mem_cmd_seq
`default_nettype wire

// File: tb/tb_btn_mem_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_mem_cmd_seq
//  Description : Directed self-checking bench for btn_mem_cmd_seq with
//                default parameters (N_BTN=3, DEB_CYC=4, BASE_ADDR=1,
//                IDLE_ADDR=15). Auto-increment checks are built only when
//                BTN_MEM_AUTO_INC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_mem_cmd_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  btn;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        cmd_ack;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  int wr_rises = 0;
  int rd_rises = 0;
  int rd_high  = 0;
  int busy_hi  = 0;
  int both_hi  = 0;
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;

  btn_mem_cmd_seq u_dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .data    (data),
    .cmd_ack (cmd_ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (wr_en === 1'b1 && wr_prev !== 1'b1) wr_rises++;
    if (rd_en === 1'b1 && rd_prev !== 1'b1) rd_rises++;
    if (rd_en === 1'b1) rd_high++;
    if (busy === 1'b1) busy_hi++;
    if (wr_en === 1'b1 && rd_en === 1'b1) both_hi++;
    wr_prev = wr_en;
    rd_prev = rd_en;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for a request to appear; returns cycles taken (budget on timeout)
  task automatic wait_cmd(input int budget, output int cyc);
    cyc = 0;
    while (!(wr_en === 1'b1 || rd_en === 1'b1) && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic ack_once();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
  endtask

  int cyc;
  int w0, r0, b0;
  logic [31:0] exp_a;

  initial begin
    rst = 1'b1; btn = 3'b110; cmd_ack = 1'b0;

    // Reset held with a button pressed
    ticks(3);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_rd_en", {63'd0, rd_en}, 64'd0);
    check("rst_addr",  {32'd0, addr},  64'd15);
    check("rst_data",  {32'd0, data},  64'd0);
    check("rst_busy",  {63'd0, busy},  64'd0);
    rst = 1'b0; btn = 3'b111;
    ticks(12);
    check("rst_no_cmd", 64'(wr_rises + rd_rises), 64'd0);

    // Single write on btn[0], ack two cycles after wr_en rises
    w0 = wr_rises;
    btn = 3'b110;
    wait_cmd(20, cyc);
    check("wr0_latency", 64'(cyc), 64'd7);
    check("wr0_wr_en", {63'd0, wr_en}, 64'd1);
    check("wr0_rd_en", {63'd0, rd_en}, 64'd0);
    check("wr0_addr",  {32'd0, addr},  64'd1);
    check("wr0_data",  {32'd0, data},  64'd1);
    check("wr0_busy",  {63'd0, busy},  64'd1);
    ticks(2);
    check("wr0_hold_en",   {63'd0, wr_en}, 64'd1);
    check("wr0_hold_addr", {32'd0, addr},  64'd1);
    check("wr0_hold_data", {32'd0, data},  64'd1);
    ack_once();
    check("wr0_done_en",   {63'd0, wr_en}, 64'd0);
    check("wr0_done_addr", {32'd0, addr},  64'd15);
    check("wr0_rel_busy",  {63'd0, busy},  64'd1);
    btn = 3'b111;
    wait_idle("wr0_idle", 30);
    check("wr0_count", 64'(wr_rises - w0), 64'd1);

    // btn[1] and btn[0] together: lowest index wins, no retrigger while held
    w0 = wr_rises; r0 = rd_rises;
    btn = 3'b100;
    wait_cmd(20, cyc);
`ifdef BTN_MEM_AUTO_INC_EN
    exp_a = 32'd2;
`else
    exp_a = 32'd1;
`endif
    check("wr1_wr_en", {63'd0, wr_en}, 64'd1);
    check("wr1_data",  {32'd0, data},  64'd1);
    check("wr1_addr",  {32'd0, addr},  {32'd0, exp_a});
    ack_once();
    ticks(15);
    check("wr1_count", 64'(wr_rises - w0 + rd_rises - r0), 64'd1);
    btn = 3'b101;
    ticks(10);
    check("wr1_count_held", 64'(wr_rises - w0 + rd_rises - r0), 64'd1);
    btn = 3'b111;
    wait_idle("wr1_idle", 30);

    // Read button with ack held high: one-cycle rd_en
    w0 = wr_rises; r0 = rd_high;
    cmd_ack = 1'b1;
    btn = 3'b011;
    wait_cmd(20, cyc);
    check("rd_latency", 64'(cyc), 64'd7);
    check("rd_rd_en", {63'd0, rd_en}, 64'd1);
    check("rd_wr_en", {63'd0, wr_en}, 64'd0);
    check("rd_addr",  {32'd0, addr},  {32'd0, exp_a});
    check("rd_data",  {32'd0, data},  64'd0);
    tick();
    check("rd_drop",  {63'd0, rd_en}, 64'd0);
    ticks(5);
    check("rd_high_cycles", 64'(rd_high - r0), 64'd1);
    check("rd_no_write",    64'(wr_rises - w0), 64'd0);
    btn = 3'b111;
    wait_idle("rd_idle", 30);
    cmd_ack = 1'b0;

    // Glitches of 2 and 3 cycles (below DEB_CYC) produce nothing
    w0 = wr_rises; b0 = busy_hi;
    btn = 3'b110; ticks(2); btn = 3'b111; ticks(15);
    btn = 3'b110; ticks(3); btn = 3'b111; ticks(15);
    check("glitch_busy",  64'(busy_hi - b0), 64'd0);
    check("glitch_no_wr", 64'(wr_rises - w0), 64'd0);

`ifdef BTN_MEM_AUTO_INC_EN
    // Fresh pointer: read before any write, then 17 writes wrapping the window
    rst = 1'b1; ticks(2); rst = 1'b0; ticks(2);
    btn = 3'b011;
    wait_cmd(20, cyc);
    check("ai_rd0_addr", {32'd0, addr}, 64'd1);
    ack_once();
    btn = 3'b111;
    wait_idle("ai_rd0_idle", 30);
    for (int k = 0; k < 17; k++) begin
      btn = 3'b110;
      wait_cmd(20, cyc);
      check($sformatf("ai_wr%0d_addr", k), {32'd0, addr}, 64'((k % 16) + 1));
      ack_once();
      btn = 3'b111;
      wait_idle("ai_wr_idle", 30);
    end
    btn = 3'b011;
    wait_cmd(20, cyc);
    check("ai_rd1_en",   {63'd0, rd_en}, 64'd1);
    check("ai_rd1_addr", {32'd0, addr},  64'd1);
    ack_once();
    btn = 3'b111;
    wait_idle("ai_rd1_idle", 30);
`endif

    check("never_both", 64'(both_hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_btn_mem_cmd_seq
`default_nettype wire
